// File: rtl/dm_ctrl.sv
// dm_ctrl -- data memory controller with valid/ready handshake.
//
// One request is accepted in IDLE. Its load/store/error result is
// resolved at the accepting edge, and the response is presented
// RD_LAT cycles later. Byte, half and word accesses are supported.
// Loads are sign- or zero-extended.
//
// Parameters:
//   DEPTH  : number of 32-bit words (power of two, >= 4)
//   RD_LAT : cycles from acceptance to rsp_valid_o (1..4)
//   AW     : request byte-address width
//
// Ports:
//   clock_i, reset_n_i          : clock, async active-low reset
//   req_valid_i / req_ready_o   : request handshake
//   req_we_i, req_size_i        : store enable, size (00 b, 01 h, 10 w, 11 rsvd)
//   req_unsigned_i              : zero-extend loads when set
//   req_addr_i, req_wdata_i     : byte address, right-aligned store data
//   rsp_valid_o / rsp_ready_i   : response handshake
//   rsp_rdata_o, rsp_err_o      : load data, error flag
//
// Optional build macro:
//   DM_BOUNDS_CHECK_EN : addresses beyond DEPTH*4 bytes are flagged as errors;
//                        when undefined they alias modulo DEPTH*4.
//
// FSM states:
//   IDLE | waiting for a request, req_ready_o = 1
//   WAIT | latency countdown, result held internally
//   RESP | rsp_valid_o = 1 until rsp_ready_i
module dm_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] res_data_q;
  logic        res_err_q;

  logic [31:0] mem_q [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             accept;
  logic             misalign;
  logic             oob;
  logic             err_d;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_val;
  logic [31:0]      res_d;
  logic [3:0]       be;
  logic [31:0]      wdata_al;

  assign idx     = req_addr_i[IDX_W+1:2];
  assign lane    = req_addr_i[1:0];
  assign accept  = req_ready_q && req_valid_i;
  assign rd_word = mem_q[idx];

`ifdef DM_BOUNDS_CHECK_EN
  assign oob = (req_addr_i >> (IDX_W + 2)) != '0;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr_i >> (IDX_W + 2));
  assign oob = 1'b0;
`endif

  always_comb begin
    misalign = 1'b0;
    case (req_size_i)
      2'b01:   misalign = lane[0];
      2'b10:   misalign = lane != 2'b00;
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  assign err_d = misalign || oob;

  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = '0;
    case (req_size_i)
      2'b00:   load_val = {{24{~req_unsigned_i & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{~req_unsigned_i & rd_half[15]}}, rd_half};
      2'b10:   load_val = rd_word;
      default: load_val = '0;
    endcase
  end

  assign res_d = (err_d || req_we_i) ? 32'h0 : load_val;

  // Store data is replicated across lanes; byte enables pick the target lanes.
  always_comb begin
    be       = 4'b0000;
    wdata_al = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be       = 4'b0001 << lane;
        wdata_al = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{req_wdata_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array is not reset; contents survive a reset pulse.
  always_ff @(posedge clock_i) begin
    if (accept && req_we_i && !err_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            res_data_q  <= res_d;
            res_err_q   <= err_d;
            req_ready_q <= 1'b0;
            if (RD_LAT == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= res_d;
              rsp_err_q   <= err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= res_data_q;
            rsp_err_q   <= res_err_q;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with RD_LAT=2, DEPTH=1024.
module tb_dm_ctrl;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int AW     = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int n_checks = 0;
  int n_fail = 0;

  dm_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .AW(AW)) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency in consumer edges, take the response.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic got;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = rsp_valid;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({name, "_drop_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({name, "_ready_back"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        got;

    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"sw_10",    1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{"lw_10",    1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"sw_20",    1'b1, SZ_W, 1'b0, 32'h20, 32'h800080F0, 32'h0,        1'b0});
    vecs.push_back('{"lb_20",    1'b0, SZ_B, 1'b0, 32'h20, 32'h0,        32'hFFFFFFF0, 1'b0});
    vecs.push_back('{"lbu_21",   1'b0, SZ_B, 1'b1, 32'h21, 32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{"lh_22",    1'b0, SZ_H, 1'b0, 32'h22, 32'h0,        32'hFFFF8000, 1'b0});
    vecs.push_back('{"lhu_22",   1'b0, SZ_H, 1'b1, 32'h22, 32'h0,        32'h00008000, 1'b0});
    vecs.push_back('{"lhu_20",   1'b0, SZ_H, 1'b1, 32'h20, 32'h0,        32'h000080F0, 1'b0});
    vecs.push_back('{"lb_23",    1'b0, SZ_B, 1'b0, 32'h23, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"lb_22",    1'b0, SZ_B, 1'b0, 32'h22, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{"sw_30",    1'b1, SZ_W, 1'b0, 32'h30, 32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{"sb_31",    1'b1, SZ_B, 1'b0, 32'h31, 32'hFFFFFFAA, 32'h0,        1'b0});
    vecs.push_back('{"sh_32",    1'b1, SZ_H, 1'b0, 32'h32, 32'hFFFFBBCC, 32'h0,        1'b0});
    vecs.push_back('{"lw_30",    1'b0, SZ_W, 1'b0, 32'h30, 32'h0,        32'hBBCCAA44, 1'b0});
    vecs.push_back('{"sw_40",    1'b1, SZ_W, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0});
    vecs.push_back('{"lw_41",    1'b0, SZ_W, 1'b0, 32'h41, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"sw_41",    1'b1, SZ_W, 1'b0, 32'h41, 32'h12345678, 32'h0,        1'b1});
    vecs.push_back('{"sh_43",    1'b1, SZ_H, 1'b0, 32'h43, 32'h0000FFFF, 32'h0,        1'b1});
    vecs.push_back('{"lh_43",    1'b0, SZ_H, 1'b0, 32'h43, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"st_rsvd",  1'b1, SZ_R, 1'b0, 32'h40, 32'h55555555, 32'h0,        1'b1});
    vecs.push_back('{"ld_rsvd",  1'b0, SZ_R, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"lw_40",    1'b0, SZ_W, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0});
    vecs.push_back('{"sw_00",    1'b1, SZ_W, 1'b0, 32'h00, 32'h01020304, 32'h0,        1'b0});
`ifdef DM_BOUNDS_CHECK_EN
    vecs.push_back('{"lw_1000",  1'b0, SZ_W, 1'b0, 32'h1000, 32'h0,      32'h0,        1'b1});
    vecs.push_back('{"sw_1000",  1'b1, SZ_W, 1'b0, 32'h1000, 32'h99999999, 32'h0,      1'b1});
    vecs.push_back('{"lw_00",    1'b0, SZ_W, 1'b0, 32'h00, 32'h0,        32'h01020304, 1'b0});
`else
    vecs.push_back('{"lw_1000",  1'b0, SZ_W, 1'b0, 32'h1000, 32'h0,      32'h01020304, 1'b0});
    vecs.push_back('{"sw_1000",  1'b1, SZ_W, 1'b0, 32'h1000, 32'h99999999, 32'h0,      1'b0});
    vecs.push_back('{"lw_00",    1'b0, SZ_W, 1'b0, 32'h00, 32'h0,        32'h99999999, 1'b0});
`endif

    foreach (vecs[k]) begin
      do_req(vecs[k].name, vecs[k].we, vecs[k].size, vecs[k].uns,
             vecs[k].addr, vecs[k].wdata, rd, er, lat);
      chk({vecs[k].name, "_rdata"}, rd, vecs[k].exp_rdata);
      chk({vecs[k].name, "_err"}, {31'h0, er}, {31'h0, vecs[k].exp_err});
      chk({vecs[k].name, "_lat"}, lat, RD_LAT);
    end

    // Backpressure: response held for 5 cycles, stray request ignored.
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("bp_rsp_seen", {31'h0, got}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_hold_ready", {31'h0, req_ready}, 32'h0);
      if (i == 2) begin
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("bp_release_valid", {31'h0, rsp_valid}, 32'h0);
    chk("bp_release_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_release_rdata", rsp_rdata, 32'h0);
    do_req("bp_reload", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("bp_reload_rdata", rd, 32'hDEADBEEF);

    // Reset during WAIT after a store was accepted.
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_W; req_addr = 32'h50;
    req_wdata = 32'h5A5A1234; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("wait_not_ready", {31'h0, req_ready}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("arst_req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    chk("arst_hold_valid", {31'h0, rsp_valid}, 32'h0);
    rst_n = 1'b1;
    do_req("arst_reload", 1'b0, SZ_W, 1'b0, 32'h50, 32'h0, rd, er, lat);
    chk("arst_reload_rdata", rd, 32'h5A5A1234);
    chk("arst_reload_err", {31'h0, er}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
